// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM responder and its storage bank.
//   resp_state_t        : responder FSM states
//   WORD_BYTES          : byte lanes per 32-bit word
//   DEFAULT_WAIT_CYCLES : wait-state count used when none is given
//   CNT_WIDTH           : width of the wait-state counter (0..15)
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  localparam int WORD_BYTES          = 4;
  localparam int DEFAULT_WAIT_CYCLES = 1;
  localparam int CNT_WIDTH           = 4;

endpackage

// File: rtl/sram_bank.sv
// Single-port word array with per-byte-lane write enables and a registered
// read port, written so it maps onto block RAM (no reset on the storage).
//   clk   : clock
//   we    : byte-lane write enables, lane i covers wdata[8*i+7:8*i]
//   addr  : word address
//   wdata : lane-aligned write data
//   rdata : word at addr, registered on every rising edge
module sram_bank
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_r [2**ADDR_WIDTH];

  // Byte-lane writes and synchronous read of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (we[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for an SRAM-style data port. Each request is latched
// on acceptance, held for WAIT_CYCLES extra cycles in BUSY, performed on the
// last BUSY edge and reported with a one-cycle mem_valid pulse from DONE.
//   clk         : clock
//   rst         : asynchronous active-low reset
//   mem_en      : request present
//   mem_wen     : byte-lane write enables (all zero = read)
//   mem_addr    : byte address, bits [1:0] ignored
//   mem_wdata   : lane-aligned write data
//   mem_rdata   : registered read data
//   mem_valid   : completion pulse
//   mem_stall   : initiator must hold its request
//   range_error : pulse with mem_valid for an out-of-range address
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_stall,
  output logic        range_error
);

  resp_state_t           state_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [3:0]            wen_r;
  logic [31:0]           wdata_r;
  logic                  oor_r;
  logic [31:0]           mem_rdata_r;
  logic                  mem_valid_r;
  logic                  range_error_r;

  logic [ADDR_WIDTH-1:0] bank_addr_s;
  logic [3:0]            bank_we_s;
  logic [31:0]           bank_rdata_s;
  logic                  oor_s;
  logic                  commit_s;
  logic                  stall_s;
  logic                  unused_addr_bits_s;

  assign unused_addr_bits_s = ^mem_addr[1:0];
  assign oor_s              = |mem_addr[31:ADDR_WIDTH+2];
  assign commit_s           = (state_r == BUSY) && (cnt_r == {CNT_WIDTH{1'b0}});

  // Bank address: in IDLE the incoming address is presented so the word is
  // already in the bank's read register on the acceptance edge; this keeps
  // reads correct even when WAIT_CYCLES is 0.
  always_comb begin
    bank_addr_s = addr_r;
    if (state_r == IDLE) begin
      bank_addr_s = mem_addr[ADDR_WIDTH+1:2];
    end else begin
      bank_addr_s = addr_r;
    end
  end

  // Write lanes fire only on the commit edge of an in-range write.
  always_comb begin
    bank_we_s = 4'b0000;
    if (commit_s && !oor_r) begin
      bank_we_s = wen_r;
    end else begin
      bank_we_s = 4'b0000;
    end
  end

  // Stall follows the request in IDLE, is forced in BUSY, released in DONE.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = mem_en;
      BUSY:    stall_s = 1'b1;
      DONE:    stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  sram_bank #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we_s),
    .addr (bank_addr_s),
    .wdata(wdata_r),
    .rdata(bank_rdata_s)
  );

  // Responder FSM: request latch, wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_WIDTH{1'b0}};
      addr_r        <= {ADDR_WIDTH{1'b0}};
      wen_r         <= 4'b0000;
      wdata_r       <= 32'h0000_0000;
      oor_r         <= 1'b0;
      mem_rdata_r   <= 32'h0000_0000;
      mem_valid_r   <= 1'b0;
      range_error_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_valid_r   <= 1'b0;
          range_error_r <= 1'b0;
          if (mem_en) begin
            addr_r  <= mem_addr[ADDR_WIDTH+1:2];
            wen_r   <= mem_wen;
            wdata_r <= mem_wdata;
            oor_r   <= oor_s;
            cnt_r   <= CNT_WIDTH'(WAIT_CYCLES);
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_r != {CNT_WIDTH{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end else begin
            state_r       <= DONE;
            mem_valid_r   <= 1'b1;
            range_error_r <= oor_r;
            // Any out-of-range access returns zero; in-range writes keep
            // the previous read data.
            if (oor_r) begin
              mem_rdata_r <= 32'h0000_0000;
            end else if (wen_r == 4'b0000) begin
              mem_rdata_r <= bank_rdata_s;
            end
          end
        end
        DONE: begin
          state_r       <= IDLE;
          mem_valid_r   <= 1'b0;
          range_error_r <= 1'b0;
        end
        default: begin
          state_r       <= IDLE;
          mem_valid_r   <= 1'b0;
          range_error_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rdata   = mem_rdata_r;
  assign mem_valid   = mem_valid_r;
  assign range_error = range_error_r;
  assign mem_stall   = stall_s;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: two instances (WAIT_CYCLES=1 and 3) share one
// request stream. Each issued access pushes the expected response into a
// per-instance queue; independent monitors pop and compare on mem_valid.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  logic [31:0] rdata1, rdata3;
  logic        valid1, valid3, stall1, stall3, rerr1, rerr3;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        rerr;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  logic [31:0] model_mem [4096];
  logic [31:0] model_rdata;
  logic [3:0]  wen_tab [9] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata1),
    .mem_valid(valid1), .mem_stall(stall1), .range_error(rerr1));

  sram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata3),
    .mem_valid(valid3), .mem_stall(stall3), .range_error(rerr3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the WAIT_CYCLES=1 instance.
  always @(negedge clk) begin
    if (rst) begin
      if (valid1) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL w1_unexpected_valid: got valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          e1 = q1.pop_front();
          chk("w1_rdata", rdata1, e1.rdata);
          chk("w1_range_error", {31'd0, rerr1}, {31'd0, e1.rerr});
          chk("w1_latency", cyc, e1.due);
        end
      end else if (rerr1) begin
        chk("w1_range_error_without_valid", {31'd0, rerr1}, 32'd0);
      end
    end
  end

  // Monitor for the WAIT_CYCLES=3 instance.
  always @(negedge clk) begin
    if (rst) begin
      if (valid3) begin
        checks++;
        if (q3.size() == 0) begin
          failures++;
          $display("FAIL w3_unexpected_valid: got valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          e3 = q3.pop_front();
          chk("w3_rdata", rdata3, e3.rdata);
          chk("w3_range_error", {31'd0, rerr3}, {31'd0, e3.rerr});
          chk("w3_latency", cyc, e3.due);
        end
      end else if (rerr3) begin
        chk("w3_range_error_without_valid", {31'd0, rerr3}, 32'd0);
      end
    end
  end

  // One access: model update, scoreboard push, stall counting over the six
  // cycles T..T+5 (the WAIT_CYCLES=3 instance completes at T+5). During the
  // stall the request inputs are scrambled; poke raises mem_en while the
  // WAIT_CYCLES=1 instance sits in DONE, which it must ignore.
  task automatic do_op(input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit poke);
    exp_t e;
    int   s1 = 0;
    int   s3 = 0;
    bit   oor = (addr[31:14] != 18'd0);
    int   idx = int'(addr[13:2]);
    if (oor) model_rdata = 32'h0;
    else if (wen == 4'h0) model_rdata = model_mem[idx];
    else begin
      for (int b = 0; b < 4; b++)
        if (wen[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end
    @(posedge clk); #1;
    mem_en = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wdata;
    e.rdata = model_rdata;
    e.rerr  = oor;
    e.due   = cyc + 1 + 2;
    q1.push_back(e);
    e.due   = cyc + 3 + 2;
    q3.push_back(e);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == 1) begin
          mem_en = 1'b0; mem_addr = $urandom; mem_wdata = $urandom; mem_wen = 4'($urandom);
        end
        if (k == 3 && poke) begin
          mem_en = 1'b1; mem_addr = $urandom_range(0, 63); mem_wen = 4'hF;
        end
        if (k == 4) mem_en = 1'b0;
      end
      @(negedge clk);
      if (stall1) s1++;
      if (stall3) s3++;
    end
    chk("w1_stall_cycles", s1, 32'd3);
    chk("w3_stall_cycles", s3, 32'd5);
  endtask

  // Outputs while reset is held low; mem_stall must track mem_en.
  task automatic reset_checks();
    @(negedge clk);
    chk("rst_w1_rdata", rdata1, 32'h0);
    chk("rst_w3_rdata", rdata3, 32'h0);
    chk("rst_valid", {30'd0, valid1, valid3}, 32'd0);
    chk("rst_range_error", {30'd0, rerr1, rerr3}, 32'd0);
    chk("rst_stall_en0", {30'd0, stall1, stall3}, 32'd0);
    mem_en = 1'b1;
    #1;
    chk("rst_stall_en1", {30'd0, stall1, stall3}, 32'd3);
    mem_en = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b0; mem_en = 1'b0; mem_wen = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    model_rdata = 32'h0;
    reset_checks();
    @(posedge clk); #1; rst = 1'b1;

    // Initialise the 16 words used by the rest of the run.
    for (int i = 0; i < 16; i++) do_op(4'hF, 32'(i * 4), $urandom, 1'b0);

    // Full-word write/read, then byte-lane merges.
    do_op(4'hF, 32'h10, 32'h1122_3344, 1'b0);
    do_op(4'h0, 32'h10, 32'h0, 1'b0);
    do_op(4'h4, 32'h10, 32'hAABB_CCDD, 1'b0);
    do_op(4'h0, 32'h10, 32'h0, 1'b0);
    do_op(4'h3, 32'h10, 32'h0000_5566, 1'b1);
    do_op(4'h0, 32'h10, 32'h0, 1'b0);
    chk("model_byte_merge", model_mem[4], 32'h11BB_5566);

    // Out of range: no write, zero data, range_error; word 0 untouched.
    do_op(4'hF, 32'h4000, 32'hDEAD_BEEF, 1'b0);
    do_op(4'h0, 32'h4000, 32'h0, 1'b0);
    do_op(4'h0, 32'h0, 32'h0, 1'b0);

    // Reset two cycles after accepting a write: the write is dropped.
    @(posedge clk); #1;
    mem_en = 1'b1; mem_wen = 4'hF; mem_addr = 32'h20; mem_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1; mem_en = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    reset_checks();
    @(posedge clk); #1; rst = 1'b1;
    model_rdata = 32'h0;
    do_op(4'h0, 32'h20, 32'h0, 1'b0);

    // Randomised mix of reads, partial writes and out-of-range accesses.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | (32'h1 << $urandom_range(14, 31));
      else a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      do_op(wen_tab[$urandom_range(0, 8)], a, $urandom, bit'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    chk("w1_queue_drained", q1.size(), 32'd0);
    chk("w3_queue_drained", q3.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the core's SRAM-style data interface: `mem_en`, `mem_wen[3:0]`, `mem_addr`, `mem_wdata` in; `mem_rdata` out.
- Serves word reads and byte-enabled writes from an on-chip word-addressed array.
- Inserts a configurable number of wait states and holds the pipeline with `mem_stall` until each access completes.
- Sits between the memory pipeline stage and the data RAM. It replaces a zero-latency ideal SRAM so the pipeline stall path gets exercised.

Parameters:
- ADDR_WIDTH, 12: word-address width; the array holds 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 1: extra cycles spent in BUSY before the access is performed (0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_en  in  1  request present.
- mem_wen  in  4  byte-lane write enables; 4'b0000 with mem_en=1 means read.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data, already lane-aligned by the initiator.
- mem_rdata  out  32  read data; registered.
- mem_valid  out  1  one-cycle pulse marking completion of an access.
- mem_stall  out  1  initiator must hold its request and freeze the pipeline.
- range_error  out  1  one-cycle pulse, coincident with mem_valid, for an out-of-range access.

Behaviour:
- **Reset** (rst=0, asynchronous): state=IDLE, wait counter=0, mem_rdata=0, mem_valid=0, range_error=0, latched request cleared. Array contents are not reset.
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - If mem_en=1: latch addr[ADDR_WIDTH+1:2], wen and wdata; load cnt=WAIT_CYCLES; next state BUSY.
  - mem_stall = mem_en (combinational) in this state.
- **BUSY:**
  - mem_stall=1.
  - If cnt!=0: decrement cnt.
  - If cnt==0: perform the access on this edge, then go to DONE.
    - Write: update byte lane i for each latched wen[i]=1.
    - Read (wen=0): capture the array word into mem_rdata.
- **DONE:**
  - mem_valid=1, mem_stall=0; next state IDLE.
  - The initiator advances on this cycle.
  - A new mem_en is sampled the following cycle, in IDLE.
- **Latency:** acceptance cycle T; mem_valid at T+WAIT_CYCLES+2. Minimum issue interval is WAIT_CYCLES+3 cycles.
- **Request stability:** request inputs are latched at acceptance. Changes while mem_stall=1 are ignored.
- **mem_rdata update rule:** updates only on completed in-range reads. It holds its value across writes and idle cycles.
- **Out of range:** any of mem_addr[31:ADDR_WIDTH+2] nonzero.
  - No array write.
  - mem_rdata loaded with 0.
  - range_error=1 in DONE.
  - Normal timing otherwise.
- **Partial wen:** any value is legal (the initiator issues 0001/0010/0100/1000/0011/1100/1111). No check is made.
- **Reset mid-operation:** returns to IDLE immediately.
  - A write not yet committed on the BUSY(cnt==0) edge is dropped.
  - A write already committed stays in the array.
- **Simultaneous mem_en in DONE:** ignored; the request is accepted the next cycle.
- **Read-after-write:** a read of a just-written word returns the new data, since the accesses are strictly sequential.

Decomposition:
- Shared package `sram_pkg`:
  - `resp_state_t` enum {IDLE, BUSY, DONE}.
  - WORD_BYTES=4.
  - Constant for the default wait count.
- One sub-module `sram_bank`:
  - Single-port array with clk, we[3:0], addr[ADDR_WIDTH-1:0], wdata, and synchronous rdata.
  - Per-lane write enables.
  - Inferable as block RAM.
- The responder keeps the FSM, counter, range check and output registers.

Test Plan:
- **Reset:** assert rst=0 mid-run → mem_rdata=0, mem_valid=0, mem_stall=mem_en, range_error=0, state IDLE.
- **Full-word write/read (WAIT_CYCLES=1):** write 0x11223344 to 0x0000_0010 with wen=1111, then read 0x0000_0010 → mem_valid at T+3, mem_rdata=0x11223344, mem_stall high at T, T+1, T+2.
- **Byte write:** write wdata=0xAABBCCDD with wen=0100 to the word from the previous scenario, then read → 0x11BB3344. Then write wen=0011 wdata=0x0000_5566 → 0x11BB5566.
- **Stall timing (WAIT_CYCLES=3):** single read → mem_stall=1 for 5 cycles (T..T+4), mem_valid at T+5. Changing mem_addr during the stall does not alter the returned word.
- **Out of range (ADDR_WIDTH=12):** write 0xDEADBEEF to 0x0000_4000, then read 0x0000_4000 → range_error pulses on each, read returns 0. Word 0x0000_0000 is unchanged.
- **Reset mid-BUSY (WAIT_CYCLES=3):** pulse rst low two cycles after accepting write 0xCAFEF00D to 0x20 → returns to IDLE, no mem_valid. A subsequent read of 0x20 returns the prior contents.
